// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: register-file geometry and the x0 address.
// Used by the register file, the hazard logic and the pending-write scoreboard.
package rv_pkg;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t X0 = '0;

endpackage

// File: rtl/reg_scoreboard_slot.sv
// One pending-write counter for a single architectural register.
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-low reset
//   inc            a counted issue targets this register
//   dec            a writeback targets this register (flush already masked out)
//   clr            flush: clear the counter, overriding inc/dec
//   cnt            current pending count
//   nz / sat       count is non-zero / count is at its maximum
//   underflow_hit  dec arrived while the count was already zero
module reg_scoreboard_slot #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             nz,
  output logic             sat,
  output logic             underflow_hit
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_dec_eff;

  // A writeback only retires something when a write is actually pending.
  assign w_dec_eff = dec && nz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && !w_dec_eff && !sat) begin
      r_cnt <= r_cnt + ONE;
    end else if (w_dec_eff && !inc) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  assign cnt           = r_cnt;
  assign nz            = |r_cnt;
  assign sat           = &r_cnt;
  assign underflow_hit = dec && !nz;

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register pending-write tracker at decode/issue. Withholds issue_ready
// on RAW hazards and on destination-counter saturation until writeback
// retires the producing write.
// Ports:
//   clk, rst                clock (rising edge), asynchronous active-low reset
//   issue_valid/issue_ready issue handshake; issue_ready is combinational
//   rs1, rs2, rs1_used, rs2_used  source operands
//   rd, rd_we               destination register and its write enable
//   wb_valid, wb_rd         writeback retiring one write
//   flush                   synchronous clear of all pending writes
//   busy                    per-register pending flags (bit 0 always 0)
//   outstanding             saturating total of pending writes
//   err_underflow           sticky: writeback to a register with nothing pending
module reg_scoreboard
  import rv_pkg::*;
#(
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned WB_BYPASS = 1,
  parameter int unsigned OUT_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  rd_we,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  flush,
  output logic [NUM_REGS-1:0]   busy,
  output logic [OUT_W-1:0]      outstanding,
  output logic                  err_underflow
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);

  logic [CNT_W-1:0]    w_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_nz;
  logic [NUM_REGS-1:0] w_sat;
  logic [NUM_REGS-1:0] w_uf;

  logic             w_rs1_blk, w_rs2_blk, w_rd_blk;
  logic [CNT_W-1:0] w_rs1_cnt, w_rs2_cnt;
  logic             w_inc_any, w_dec_any;
  logic [OUT_W-1:0] r_out;
  logic             r_err;

  // Slot 0 is x0 and is never tracked.
  assign w_cnt[0] = '0;
  assign w_nz[0]  = 1'b0;
  assign w_sat[0] = 1'b0;
  assign w_uf[0]  = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_slot
    logic w_inc, w_dec;
    assign w_inc = w_inc_any && (rd == REG_ADDR_W'(i));
    assign w_dec = wb_valid && !flush && (wb_rd == REG_ADDR_W'(i));

    reg_scoreboard_slot #(.CNT_W(CNT_W)) u_slot (
      .clk           (clk),
      .rst           (rst),
      .inc           (w_inc),
      .dec           (w_dec),
      .clr           (flush),
      .cnt           (w_cnt[i]),
      .nz            (w_nz[i]),
      .sat           (w_sat[i]),
      .underflow_hit (w_uf[i])
    );
  end

  assign w_rs1_cnt = w_cnt[rs1];
  assign w_rs2_cnt = w_cnt[rs2];

  // A source whose last pending write is retiring this very cycle is not
  // blocked when bypassing is enabled.
  always_comb begin
    w_rs1_blk = rs1_used && (rs1 != X0) && (w_rs1_cnt != '0) &&
                !((WB_BYPASS != 0) && wb_valid && (wb_rd == rs1) && (w_rs1_cnt == CNT_ONE));
    w_rs2_blk = rs2_used && (rs2 != X0) && (w_rs2_cnt != '0) &&
                !((WB_BYPASS != 0) && wb_valid && (wb_rd == rs2) && (w_rs2_cnt == CNT_ONE));
    w_rd_blk  = rd_we && (rd != X0) && w_sat[rd] && !(wb_valid && (wb_rd == rd));
  end

  assign issue_ready = !w_rs1_blk && !w_rs2_blk && !w_rd_blk;

  assign w_inc_any = issue_valid && issue_ready && rd_we && (rd != X0) && !flush;
  assign w_dec_any = wb_valid && (wb_rd != X0) && w_nz[wb_rd] && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out <= '0;
    end else if (flush) begin
      r_out <= '0;
    end else if (w_inc_any && !w_dec_any && (r_out != '1)) begin
      r_out <= r_out + OUT_ONE;
    end else if (w_dec_any && !w_inc_any && (r_out != '0)) begin
      r_out <= r_out - OUT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (|w_uf) begin
      r_err <= 1'b1;
    end
  end

  assign busy          = w_nz;
  assign outstanding   = r_out;
  assign err_underflow = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic        rs1_used, rs2_used, rd_we, wb_valid, flush;
  logic [31:0] busy;
  logic [3:0]  outstanding;
  logic        err_underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.CNT_W(2), .WB_BYPASS(1), .OUT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .rs1           (rs1),
    .rs2           (rs2),
    .rs1_used      (rs1_used),
    .rs2_used      (rs2_used),
    .rd            (rd),
    .rd_we         (rd_we),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .flush         (flush),
    .busy          (busy),
    .outstanding   (outstanding),
    .err_underflow (err_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
    rd = 0; rd_we = 0; wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle issue that writes r.
  task automatic fire(input logic [4:0] r);
    idle(); issue_valid = 1; rd = r; rd_we = 1;
    tick(); idle();
  endtask

  // One-cycle writeback to r.
  task automatic wb(input logic [4:0] r);
    idle(); wb_valid = 1; wb_rd = r;
    tick(); idle();
  endtask

  initial begin
    idle();
    rst = 0;
    tick(); tick();
    chk("rst_busy", busy, 32'h0);
    chk("rst_out", {28'h0, outstanding}, 32'd0);
    chk("rst_err", {31'h0, err_underflow}, 32'd0);
    chk("rst_ready", {31'h0, issue_ready}, 32'd1);
    rst = 1;
    tick();

    // RAW hazard on x5 with same-cycle writeback bypass
    fire(5'd5);
    chk("raw_busy", busy, 32'h20);
    chk("raw_out", {28'h0, outstanding}, 32'd1);
    issue_valid = 1; rs1 = 5; rs1_used = 1; #1;
    chk("raw_blocked", {31'h0, issue_ready}, 32'd0);
    wb_valid = 1; wb_rd = 5; #1;
    chk("raw_bypass", {31'h0, issue_ready}, 32'd1);
    tick(); idle();
    chk("raw_busy_clr", busy, 32'h0);
    chk("raw_out_clr", {28'h0, outstanding}, 32'd0);

    // x0 and unused sources
    fire(5'd0);
    chk("x0_busy", busy, 32'h0);
    chk("x0_out", {28'h0, outstanding}, 32'd0);
    wb(5'd0);
    chk("x0_wb_err", {31'h0, err_underflow}, 32'd0);
    fire(5'd7);
    chk("r7_busy", busy, 32'h80);
    issue_valid = 1; rs1 = 7; rs1_used = 0; #1;
    chk("unused_ready", {31'h0, issue_ready}, 32'd1);
    rs2 = 7; rs2_used = 1; #1;
    chk("rs2_blocked", {31'h0, issue_ready}, 32'd0);
    idle();
    wb(5'd7);
    chk("r7_clr", busy, 32'h0);

    // Saturation of x9
    fire(5'd9); fire(5'd9); fire(5'd9);
    chk("sat_out", {28'h0, outstanding}, 32'd3);
    chk("sat_busy", busy, 32'h200);
    issue_valid = 1; rd = 9; rd_we = 1; #1;
    chk("sat_blocked", {31'h0, issue_ready}, 32'd0);
    tick();
    chk("sat_nofire_out", {28'h0, outstanding}, 32'd3);
    wb_valid = 1; wb_rd = 9; #1;
    chk("sat_wb_ready", {31'h0, issue_ready}, 32'd1);
    tick(); idle();
    chk("sat_net_out", {28'h0, outstanding}, 32'd3);
    wb(5'd9); wb(5'd9);
    chk("sat_drain2_busy", busy, 32'h200);
    chk("sat_drain2_out", {28'h0, outstanding}, 32'd1);
    wb(5'd9);
    chk("sat_drain3_busy", busy, 32'h0);
    chk("sat_drain3_out", {28'h0, outstanding}, 32'd0);

    // Same-cycle issue and writeback
    fire(5'd4); fire(5'd6);
    chk("sc_setup_out", {28'h0, outstanding}, 32'd2);
    issue_valid = 1; rd = 4; rd_we = 1; wb_valid = 1; wb_rd = 4;
    tick(); idle();
    chk("sc_same_busy", busy, 32'h50);
    chk("sc_same_out", {28'h0, outstanding}, 32'd2);
    issue_valid = 1; rd = 4; rd_we = 1; wb_valid = 1; wb_rd = 6;
    tick(); idle();
    chk("sc_diff_busy", busy, 32'h10);
    chk("sc_diff_out", {28'h0, outstanding}, 32'd2);
    wb(5'd4);
    chk("sc_cnt4_busy", busy, 32'h10);
    wb(5'd4);
    chk("sc_cnt4_clr", busy, 32'h0);
    chk("sc_out_clr", {28'h0, outstanding}, 32'd0);

    // Outstanding saturates at 15 (6 registers x 3 writes = 18)
    for (int r = 1; r <= 6; r++) begin
      fire(5'(r)); fire(5'(r)); fire(5'(r));
    end
    chk("out_sat", {28'h0, outstanding}, 32'd15);
    chk("out_sat_busy", busy, 32'h7E);
    idle(); flush = 1; tick(); idle();
    chk("out_sat_flush", {28'h0, outstanding}, 32'd0);

    // Underflow and flush
    wb(5'd12);
    chk("uf_err", {31'h0, err_underflow}, 32'd1);
    chk("uf_busy", busy, 32'h0);
    chk("uf_out", {28'h0, outstanding}, 32'd0);
    fire(5'd3); fire(5'd8);
    chk("fl_setup_out", {28'h0, outstanding}, 32'd2);
    issue_valid = 1; rd = 10; rd_we = 1; wb_valid = 1; wb_rd = 3; flush = 1;
    rs1 = 8; rs1_used = 1; #1;
    chk("fl_ready_from_cnt", {31'h0, issue_ready}, 32'd0);
    tick(); idle();
    chk("fl_busy", busy, 32'h0);
    chk("fl_out", {28'h0, outstanding}, 32'd0);
    chk("fl_err_kept", {31'h0, err_underflow}, 32'd1);

    // Asynchronous reset mid-cycle
    fire(5'd1); fire(5'd2); fire(5'd3);
    chk("ar_out", {28'h0, outstanding}, 32'd3);
    #2 rst = 0;
    #1;
    chk("ar_busy", busy, 32'h0);
    chk("ar_out0", {28'h0, outstanding}, 32'd0);
    chk("ar_err", {31'h0, err_underflow}, 32'd0);
    tick();
    rst = 1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
